periph_bus_ctrl: RTL and testbench
==================================

# periph_bus_ctrl

Parametrised peripheral bus controller between the maxicore32 bus and up to `NUM_SLAVES` memory/IO slaves. It replaces the board-level combinational decode and read mux. It adds registered slave selects, a per-access ready handshake so slow slaves can insert wait states, a registered read-data mux, and a timeout that converts hung or unmapped accesses into a bus error. One instance sits in each board top level between the processor and the slave modules.

## Interface
- `NUM_SLAVES`, default 8: number of slave channels, 1..16.
- `CLASS_BASE`, default 8'h00: address class (`address[31:24]`) that maps to slave 0. Slave i maps to class `CLASS_BASE+i`.
- `TIMEOUT_CYCLES`, default 16: cycles a selected slave may hold off ready before the access is aborted, 2..255.
- `clock`  in  1  bus clock (cpu_clock domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  30  processor word address [31:2].
- `read`, `write`  in  1 each  processor access request; level-held until `ready`.
- `data_strobes`  in  4  byte lanes, passed through to slaves unchanged.
- `cpu_data_in`  out  32  registered read data to processor.
- `ready`  out  1  one-cycle access-complete pulse.
- `bus_error`  out  1  one-cycle pulse coincident with `ready` on an aborted access.
- `slave_cs`  out  NUM_SLAVES  registered one-hot select.
- `slave_read`, `slave_write`  out  1 each  registered qualified strobes.
- `slave_data_out`  in  32*NUM_SLAVES  flattened slave read data; slave i occupies bits [32i+31:32i].
- `slave_ready`  in  NUM_SLAVES  per-slave completion; sampled only for the selected slave.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, with `read` xor `write` asserted:
  - class = `address[31:24] - CLASS_BASE`, computed 8-bit with wrap.
  - If class < NUM_SLAVES: latch class, assert `slave_cs[class]` and the matching strobe, clear the timeout counter, go to ACCESS.
  - Otherwise (unmapped): go to DONE with error flag set.
- IDLE, with `read` and `write` both high: illegal; go to DONE with error flag set, no slave selected.
- ACCESS:
  - Counter increments each cycle.
  - Selected `slave_ready` high: on reads, capture that slave's data into `cpu_data_in`. Drop cs/strobes, go to DONE with error flag clear.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: drop cs/strobes, `cpu_data_in` = 32'hDEAD_BEEF, go to DONE with error flag set.
  - Ready arriving in the same cycle as the timeout wins: the access completes normally.
- DONE:
  - Pulse `ready` for one cycle; pulse `bus_error` if the error flag is set.
  - Return to IDLE.
  - A request still held high in that IDLE cycle starts a new access; the processor must drop its request on `ready`.
- Writes leave `cpu_data_in` unchanged. Non-selected slaves' `slave_ready` and data are ignored.
- Reset values: state IDLE, `slave_cs` = 0, `slave_read` = `slave_write` = 0, `ready` = 0, `bus_error` = 0, `cpu_data_in` = 0.
- Reset asserted mid-access aborts immediately with outputs at reset values. No ready or error is produced for the aborted access.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- Minimum access, for a slave with ready in its first ACCESS cycle:
  - cycle 0: request sampled in IDLE.
  - cycle 1: ACCESS, cs high.
  - cycle 2: DONE, `ready` high.
  - Three cycles request to request.
- Each additional cycle the slave holds off ready adds one cycle.
- Timeout: `ready` plus `bus_error` appear TIMEOUT_CYCLES+1 cycles after the request is sampled.
- Unmapped or illegal request: `ready` plus `bus_error` on cycle 1.
- `slave_cs` is held for the whole ACCESS state. Slaves may register `write` on any cycle in which cs is high; the controller guarantees exactly one contiguous cs window per access.

## Structure
- Shared package `bus_pkg` holds:
  - state enum (IDLE/ACCESS/DONE);
  - `BUS_ERROR_DATA` = 32'hDEAD_BEEF;
  - class width constant (8) and data width constant (32).
- One natural sub-module, `bus_timeout_counter`: an 8-bit counter with clear/enable and a terminal-count flag compared against TIMEOUT_CYCLES-1.
- The read mux is an indexed part-select of `slave_data_out` by the latched class. No separate module.

## Test plan
- Read, class 8'h00, slave 0 ready on first ACCESS cycle with data 32'h1234_5678 -> `ready` on cycle 2, `cpu_data_in` = 32'h1234_5678, `bus_error` = 0, `slave_cs` = 8'b0000_0001 for exactly one cycle.
- Write, class 8'h03, slave 3 ready after 4 wait cycles -> `slave_write` and `slave_cs[3]` high for 5 cycles, `ready` on cycle 6, `cpu_data_in` unchanged.
- Read, class 8'h05, slave never ready, TIMEOUT_CYCLES = 16 -> `ready` and `bus_error` on cycle 17, `cpu_data_in` = 32'hDEAD_BEEF, cs low afterwards.
- Read, class 8'h20 (unmapped) and separately `read` = `write` = 1 -> `ready` and `bus_error` on cycle 1, no `slave_cs` bit ever set.
- Slave ready in exactly the timeout cycle with data 32'hCAFE_0001 -> normal completion, `bus_error` = 0, data = 32'hCAFE_0001.
- `reset_n` pulled low for 1 cycle during ACCESS -> all outputs 0 immediately, no `ready`. After release, a held request is re-sampled and completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the peripheral bus controller
//
// Holds the controller state encoding, the data returned on aborted reads,
// and the address-class and data widths used across the bus logic.
package bus_pkg;

  localparam int CLASS_W = 8;
  localparam int DATA_W  = 32;

  localparam logic [DATA_W-1:0] BUS_ERROR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - 8-bit access timeout counter with terminal flag
//
// Ports:
//   clock     in   bus clock
//   reset_n   in   asynchronous active-low reset
//   clear     in   reset count to zero (takes priority over enable)
//   enable    in   increment count by one
//   terminal  out  high while count equals TIMEOUT_CYCLES-1
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CLASS_W-1:0] TC_VALUE = CLASS_W'(TIMEOUT_CYCLES - 1);

  logic [CLASS_W-1:0] count_q;
  logic [CLASS_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == TC_VALUE);

endmodule

// File: rtl/periph_bus_ctrl.sv
// rtl/periph_bus_ctrl.sv - processor-to-slave bus controller with wait states and timeout
//
// Ports:
//   clock               in   bus clock
//   reset_n             in   asynchronous active-low reset
//   address             in   processor word address [31:2]; bits [31:24] select the slave class
//   read, write         in   access request, held until ready
//   data_strobes        in   byte lanes for the access
//   cpu_data_in         out  registered read data to the processor
//   ready               out  one-cycle access-complete pulse
//   bus_error           out  one-cycle pulse with ready on an aborted access
//   slave_cs            out  registered one-hot slave select
//   slave_read          out  registered read strobe to the selected slave
//   slave_write         out  registered write strobe to the selected slave
//   slave_data_strobes  out  byte lanes latched with the request, held for the access
//   slave_data_out      in   flattened slave read data, slave i at [32i+31:32i]
//   slave_ready         in   per-slave completion, only the selected one is looked at
module periph_bus_ctrl
  import bus_pkg::*;
#(
  parameter int                 NUM_SLAVES     = 8,
  parameter logic [CLASS_W-1:0] CLASS_BASE     = 8'h00,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [29:0]                  address,
  input  logic                         read,
  input  logic                         write,
  input  logic [3:0]                   data_strobes,
  output logic [DATA_W-1:0]            cpu_data_in,
  output logic                         ready,
  output logic                         bus_error,
  output logic [NUM_SLAVES-1:0]        slave_cs,
  output logic                         slave_read,
  output logic                         slave_write,
  output logic [3:0]                   slave_data_strobes,
  input  logic [DATA_W*NUM_SLAVES-1:0] slave_data_out,
  input  logic [NUM_SLAVES-1:0]        slave_ready
);

  localparam logic [CLASS_W-1:0] NUM_SLAVES_C = CLASS_W'(NUM_SLAVES);

  bus_state_e              state_q, state_d;
  logic [CLASS_W-1:0]      class_q, class_d;
  logic [NUM_SLAVES-1:0]   cs_q, cs_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [3:0]              strb_q, strb_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       data_q, data_d;

  logic [CLASS_W-1:0]      req_class;
  logic [NUM_SLAVES-1:0]   req_cs;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_data;
  logic                    cnt_clear;
  logic                    cnt_enable;
  logic                    cnt_terminal;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^address[21:0];

  // address[29:22] is byte-address bits [31:24]; wraps so bases near 8'hFF work.
  assign req_class = address[29:22] - CLASS_BASE;

  always_comb begin
    req_cs = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_cs[i] = (req_class == CLASS_W'(i));
    end
  end

  // Read mux and ready select keyed on the class latched at request time.
  always_comb begin
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (class_q == CLASS_W'(i)) begin
        sel_ready = slave_ready[i];
        sel_data  = slave_data_out[DATA_W*i +: DATA_W];
      end
    end
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    cs_d       = cs_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    strb_d     = strb_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    data_d     = data_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (read && write) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else if (read || write) begin
          if (req_class < NUM_SLAVES_C) begin
            class_d   = req_class;
            cs_d      = req_cs;
            rd_d      = read;
            wr_d      = write;
            strb_d    = data_strobes;
            cnt_clear = 1'b1;
            state_d   = ST_ACCESS;
          end else begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        cnt_enable = 1'b1;
        // Ready is tested before the terminal count so a late slave still wins.
        if (sel_ready) begin
          if (rd_q) begin
            data_d = sel_data;
          end
          cs_d    = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_terminal) begin
          cs_d    = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          data_d  = BUS_ERROR_DATA;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      class_q <= '0;
      cs_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign cpu_data_in        = data_q;
  assign ready              = ready_q;
  assign bus_error          = err_q;
  assign slave_cs           = cs_q;
  assign slave_read         = rd_q;
  assign slave_write        = wr_q;
  assign slave_data_strobes = strb_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb/tb_periph_bus_ctrl.sv - directed self-checking bench for periph_bus_ctrl
module tb_periph_bus_ctrl;

  localparam int NS = 8;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [29:0]     address;
  logic            read, write;
  logic [3:0]      data_strobes;
  logic [31:0]     cpu_data_in;
  logic            ready, bus_error;
  logic [NS-1:0]   slave_cs;
  logic            slave_read, slave_write;
  logic [3:0]      slave_data_strobes;
  logic [32*NS-1:0] slave_data_out;
  logic [NS-1:0]   slave_ready;

  int errors = 0;
  int checks = 0;

  int   r_ready_at, r_err_at, r_cs_cycles, r_strb_cycles;
  logic r_cs_bad, r_after_ok;

  periph_bus_ctrl #(
    .NUM_SLAVES(NS), .CLASS_BASE(8'h00), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .data_strobes(data_strobes), .cpu_data_in(cpu_data_in), .ready(ready),
    .bus_error(bus_error), .slave_cs(slave_cs), .slave_read(slave_read),
    .slave_write(slave_write), .slave_data_strobes(slave_data_strobes),
    .slave_data_out(slave_data_out), .slave_ready(slave_ready)
  );

  always #5 clock = ~clock;

  // Issues one request and records, per observed cycle after the sampling edge,
  // when ready/bus_error appear and how long the expected select is held.
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] cls,
                           input int slv, input int rdy_cyc, input logic [31:0] rdata,
                           input logic noise);
    @(negedge clock);
    address        = {cls, 22'h00ABC};
    read           = rd;
    write          = wr;
    data_strobes   = 4'hA;
    slave_data_out = {NS{32'h5A5A_0000}};
    slave_ready    = noise ? '1 : '0;
    if (slv >= 0) begin
      slave_data_out[32*slv +: 32] = rdata;
      slave_ready[slv] = 1'b0;
    end
    r_ready_at = -1; r_err_at = -1; r_cs_cycles = 0; r_strb_cycles = 0; r_cs_bad = 1'b0;
    for (int cyc = 1; cyc <= 40 && r_ready_at < 0; cyc++) begin
      @(negedge clock);
      if (slave_cs != '0) begin
        if (slv >= 0 && slave_cs == (NS'(1) << slv)) r_cs_cycles++;
        else r_cs_bad = 1'b1;
      end
      if (slv >= 0 && (rd ? slave_read : slave_write)) r_strb_cycles++;
      if (bus_error) r_err_at = cyc;
      if (ready) begin
        r_ready_at = cyc;
        read  = 1'b0;
        write = 1'b0;
      end
      if (slv >= 0) slave_ready[slv] = (cyc == rdy_cyc);
    end
    slave_ready = '0;
    @(negedge clock);
    r_after_ok = (slave_cs == '0) && !ready && !bus_error && !slave_read && !slave_write;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_strobes = '0;
    slave_data_out = '0; slave_ready = '0;
    repeat (2) @(negedge clock);
    checks++; if ({slave_cs, slave_read, slave_write} !== '0) begin errors++;
      $display("FAIL reset_selects: got %b expected 0", {slave_cs, slave_read, slave_write}); end
    checks++; if ({ready, bus_error} !== 2'b00) begin errors++;
      $display("FAIL reset_ready: got %b expected 00", {ready, bus_error}); end
    checks++; if (cpu_data_in !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 0", cpu_data_in); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if ({ready, slave_cs} !== '0) begin errors++;
      $display("FAIL idle_quiet: got %b expected 0", {ready, slave_cs}); end
  endtask

  task automatic test_min_read();
    do_access(1'b1, 1'b0, 8'h00, 0, 1, 32'h1234_5678, 1'b0);
    checks++; if (r_ready_at !== 2) begin errors++;
      $display("FAIL min_read_ready_cycle: got %0d expected 2", r_ready_at); end
    checks++; if (r_err_at !== -1) begin errors++;
      $display("FAIL min_read_error: got %0d expected -1", r_err_at); end
    checks++; if (cpu_data_in !== 32'h1234_5678) begin errors++;
      $display("FAIL min_read_data: got %h expected 12345678", cpu_data_in); end
    checks++; if (r_cs_cycles !== 1 || r_cs_bad !== 1'b0 || r_strb_cycles !== 1) begin errors++;
      $display("FAIL min_read_cs: cs=%0d bad=%b rd=%0d expected 1 0 1", r_cs_cycles, r_cs_bad, r_strb_cycles); end
    checks++; if (r_after_ok !== 1'b1) begin errors++;
      $display("FAIL min_read_after: got %b expected 1", r_after_ok); end
    checks++; if (slave_data_strobes !== 4'hA) begin errors++;
      $display("FAIL min_read_strobes: got %h expected a", slave_data_strobes); end
  endtask

  task automatic test_wait_write();
    do_access(1'b0, 1'b1, 8'h03, 3, 5, 32'hFFFF_0003, 1'b1);
    checks++; if (r_ready_at !== 6 || r_err_at !== -1) begin errors++;
      $display("FAIL wait_write_ready: got ready %0d err %0d expected 6 -1", r_ready_at, r_err_at); end
    checks++; if (r_cs_cycles !== 5 || r_strb_cycles !== 5 || r_cs_bad !== 1'b0) begin errors++;
      $display("FAIL wait_write_cs: cs=%0d wr=%0d bad=%b expected 5 5 0", r_cs_cycles, r_strb_cycles, r_cs_bad); end
    checks++; if (cpu_data_in !== 32'h1234_5678) begin errors++;
      $display("FAIL wait_write_data: got %h expected 12345678", cpu_data_in); end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 8'h05, 5, -1, 32'h0000_0005, 1'b0);
    checks++; if (r_ready_at !== TO + 1 || r_err_at !== TO + 1) begin errors++;
      $display("FAIL timeout_cycle: got ready %0d err %0d expected 17 17", r_ready_at, r_err_at); end
    checks++; if (cpu_data_in !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL timeout_data: got %h expected deadbeef", cpu_data_in); end
    checks++; if (r_cs_cycles !== TO || r_after_ok !== 1'b1) begin errors++;
      $display("FAIL timeout_cs: cs=%0d after=%b expected 16 1", r_cs_cycles, r_after_ok); end
  endtask

  task automatic test_unmapped();
    logic [7:0] cls_tab [3];
    cls_tab[0] = 8'h08; cls_tab[1] = 8'h20; cls_tab[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      do_access(1'b1, 1'b0, cls_tab[k], -1, -1, 32'h0, 1'b1);
      checks++; if (r_ready_at !== 1 || r_err_at !== 1 || r_cs_bad !== 1'b0) begin errors++;
        $display("FAIL unmapped_%h: ready %0d err %0d csbad %b expected 1 1 0", cls_tab[k], r_ready_at, r_err_at, r_cs_bad); end
    end
    checks++; if (cpu_data_in !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL unmapped_data: got %h expected deadbeef", cpu_data_in); end
  endtask

  task automatic test_illegal();
    do_access(1'b1, 1'b1, 8'h02, -1, -1, 32'h0, 1'b1);
    checks++; if (r_ready_at !== 1 || r_err_at !== 1 || r_cs_bad !== 1'b0 || r_after_ok !== 1'b1) begin errors++;
      $display("FAIL illegal_rw: ready %0d err %0d csbad %b after %b expected 1 1 0 1", r_ready_at, r_err_at, r_cs_bad, r_after_ok); end
  endtask

  task automatic test_timeout_race();
    do_access(1'b1, 1'b0, 8'h06, 6, TO, 32'hCAFE_0001, 1'b0);
    checks++; if (r_ready_at !== TO + 1 || r_err_at !== -1) begin errors++;
      $display("FAIL race_ready: got ready %0d err %0d expected 17 -1", r_ready_at, r_err_at); end
    checks++; if (cpu_data_in !== 32'hCAFE_0001) begin errors++;
      $display("FAIL race_data: got %h expected cafe0001", cpu_data_in); end
  endtask

  task automatic test_back_to_back();
    int mask = 0;
    int cs_n = 0;
    @(negedge clock);
    address = {8'h07, 22'h0};
    read = 1'b1; write = 1'b0;
    slave_data_out = {NS{32'h5A5A_0000}};
    slave_data_out[32*7 +: 32] = 32'h7777_0007;
    slave_ready = 8'h80;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      if (ready) mask |= (1 << cyc);
      if (slave_cs == 8'h80) cs_n++;
    end
    read = 1'b0; slave_ready = '0;
    @(negedge clock);
    checks++; if (mask !== ((1 << 2) | (1 << 5) | (1 << 8))) begin errors++;
      $display("FAIL b2b_ready_cycles: got %h expected 124", mask); end
    checks++; if (cs_n !== 3) begin errors++;
      $display("FAIL b2b_cs_cycles: got %0d expected 3", cs_n); end
    checks++; if (cpu_data_in !== 32'h7777_0007) begin errors++;
      $display("FAIL b2b_data: got %h expected 77770007", cpu_data_in); end
  endtask

  task automatic test_reset_mid();
    int got = -1;
    logic saw_ready = 1'b0;
    @(negedge clock);
    address = {8'h01, 22'h0};
    read = 1'b1; write = 1'b0;
    slave_data_out[32*1 +: 32] = 32'h1111_2222;
    slave_ready = '0;
    @(negedge clock);
    checks++; if (slave_cs !== 8'h02) begin errors++;
      $display("FAIL mid_cs_before: got %b expected 00000010", slave_cs); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({slave_cs, slave_read, ready, bus_error} !== '0 || cpu_data_in !== 32'h0) begin errors++;
      $display("FAIL mid_reset_outputs: cs %b rd %b rdy %b data %h expected all 0", slave_cs, slave_read, ready, cpu_data_in); end
    @(negedge clock);
    if (ready) saw_ready = 1'b1;
    reset_n = 1'b1;
    slave_ready = 8'h02;
    for (int cyc = 1; cyc <= 10 && got < 0; cyc++) begin
      @(negedge clock);
      if (ready) begin got = cyc; read = 1'b0; end
    end
    slave_ready = '0;
    checks++; if (saw_ready !== 1'b0 || got !== 2 || bus_error !== 1'b0) begin errors++;
      $display("FAIL mid_resample: ready_in_reset %b ready_at %0d err %b expected 0 2 0", saw_ready, got, bus_error); end
    checks++; if (cpu_data_in !== 32'h1111_2222) begin errors++;
      $display("FAIL mid_data: got %h expected 11112222", cpu_data_in); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_min_read();
    test_wait_write();
    test_timeout();
    test_unmapped();
    test_illegal();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
